ddr3_app_arbiter: RTL and testbench
===================================

// Module: ddr3_app_arbiter
// PURPOSE
//  Two-requester round-robin arbiter in front of the MIG 7-series app_* user interface (ui_clk domain).
//  Serialises single-beat write/read commands from two clients onto one app port, sequences the app_en/app_wdf_wren handshake,
//  and returns read data to the issuing client in order using a tag FIFO. Holds all grants until calib_done.
// PARAMETERS
//  ADDR_W     29   app_addr width
//  DATA_W     256  app data width (one full burst, app_wdf_end tied 1)
//  TAG_DEPTH  8    max outstanding reads (tag FIFO depth, power of 2, >=2)
// PORTS
//  ui_clk            in   1       MIG user clock; all logic on rising edge
//  rstn              in   1       synchronous reset, active low
//  calib_done        in   1       MIG init_calib_complete
//  p0_req/p1_req     in   1       command request; held with cmd/addr/wdata until ack
//  p0_wr/p1_wr       in   1       1=write, 0=read
//  p0_addr/p1_addr   in   ADDR_W  command address
//  p0_wdata/p1_wdata in   DATA_W  write data
//  p0_ack/p1_ack     out  1       1-cycle pulse: command accepted by MIG
//  p0_rd_valid/p1_rd_valid out 1  1-cycle pulse: read data for this client
//  rd_data           out  DATA_W  read data (shared; qualified by pN_rd_valid)
//  app_en/app_cmd    out  1/3     MIG command strobe / cmd (000 write, 001 read)
//  app_addr          out  ADDR_W  MIG address
//  app_wdf_wren      out  1       MIG write-data strobe
//  app_wdf_data      out  DATA_W  MIG write data
//  app_wdf_end       out  1       constant 1
//  app_wdf_mask      out  DATA_W/8 constant 0
//  app_rdy/app_wdf_rdy in 1       MIG command / write-data ready
//  app_rd_data_valid in 1; app_rd_data in DATA_W  MIG read return
//  busy              out  1       state != IDLE or tag FIFO non-empty
//  err_unexp_rd      out  1       sticky: read data arrived with tag FIFO empty
// BEHAVIOUR
//  Reset (rstn=0 at edge): every output 0 (app_wdf_end=1 always); state=IDLE; tag FIFO empty; rr pointer=1 (p0 wins first).
//  FSM IDLE: eligible(n) = pN_req & ~pN_ack & calib_done & (pN_wr | tag_count<TAG_DEPTH).
//   One eligible -> grant it; both -> grant the one not granted last; grant updates rr pointer.
//   On grant: register cmd/addr/wdata onto app_*; app_en<=1; app_wdf_wren<=pN_wr; state->ISSUE.
//  ISSUE: app_en drops the cycle after app_en&app_rdy; app_wdf_wren drops the cycle after app_wdf_wren&app_wdf_rdy (independent;
//   write data may be accepted before, with or after command). When both are accepted (this cycle or earlier): pN_ack<=1 for one cycle, state->IDLE.
//   Read: tag (granted id) pushed in the cycle app_en&app_rdy.
//  Grant latency: req in IDLE -> app_en next cycle. Min command spacing per client: 3 cycles (grant, accept, ack/IDLE).
//  Ack cycle: the acked client is ineligible that cycle (req may still be high); the other client may be granted.
//  Read return: app_rd_data_valid -> pop tag; rd_data<=app_rd_data, p[tag]_rd_valid<=1 next cycle. Order = issue order.
//  Push and pop same cycle: count unchanged. Valid with FIFO empty: data dropped, err_unexp_rd<=1 (cleared only by reset).
//  Full: tag_count==TAG_DEPTH blocks read grants only; writes still granted.
//  calib_done falling mid-ISSUE: current command completes; no new grants.
//  Reset mid-operation: app_en/app_wdf_wren drop next edge, outstanding tags discarded; late MIG data then sets err_unexp_rd.
//  No combinational path from app_* inputs to app_* outputs; all outputs registered.
// TESTING
//  Single write p0 addr 0x40 data 256'hcafebabe..., app_rdy=app_wdf_rdy=1 -> app_en 1 cycle, cmd 000, p0_ack 2 cycles after req.
//  Write with app_wdf_rdy low 5 cycles after app_rdy accept -> app_en 1 cycle, wren held 6 cycles, ack after wdf accept only.
//  p0,p1 requesting continuously -> grants alternate p0,p1,p0...; no client granted twice in a row.
//  9 reads p0/p1 interleaved, app_rd_data_valid withheld -> 8 issued, 9th stalls; release returns data to correct client in order.
//  app_rd_data_valid with no outstanding read -> no pN_rd_valid, err_unexp_rd=1 until rstn=0.
//  calib_done=0 with requests pending -> no app_en; rstn=0 during ISSUE -> all outputs 0 next edge, busy=0.

Source files
------------

// File: rtl/ddr3_app_arbiter_if.sv
// Bundle of client-side and MIG app_* signals seen by ddr3_app_arbiter.
// slave = the arbiter's view, master = the surrounding system / bench view.
interface ddr3_app_arbiter_if #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 256
);
  logic                  calib_done;

  logic                  p0_req;
  logic                  p0_wr;
  logic [ADDR_W-1:0]     p0_addr;
  logic [DATA_W-1:0]     p0_wdata;
  logic                  p0_ack;
  logic                  p0_rd_valid;

  logic                  p1_req;
  logic                  p1_wr;
  logic [ADDR_W-1:0]     p1_addr;
  logic [DATA_W-1:0]     p1_wdata;
  logic                  p1_ack;
  logic                  p1_rd_valid;

  logic [DATA_W-1:0]     rd_data;

  logic                  app_en;
  logic [2:0]            app_cmd;
  logic [ADDR_W-1:0]     app_addr;
  logic                  app_wdf_wren;
  logic [DATA_W-1:0]     app_wdf_data;
  logic                  app_wdf_end;
  logic [DATA_W/8-1:0]   app_wdf_mask;
  logic                  app_rdy;
  logic                  app_wdf_rdy;
  logic                  app_rd_data_valid;
  logic [DATA_W-1:0]     app_rd_data;

  logic                  busy;
  logic                  err_unexp_rd;

  modport slave (
    input  calib_done,
    input  p0_req, p0_wr, p0_addr, p0_wdata,
    output p0_ack, p0_rd_valid,
    input  p1_req, p1_wr, p1_addr, p1_wdata,
    output p1_ack, p1_rd_valid,
    output rd_data,
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data, app_wdf_end, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
    output busy, err_unexp_rd
  );

  modport master (
    output calib_done,
    output p0_req, p0_wr, p0_addr, p0_wdata,
    input  p0_ack, p0_rd_valid,
    output p1_req, p1_wr, p1_addr, p1_wdata,
    input  p1_ack, p1_rd_valid,
    input  rd_data,
    input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data, app_wdf_end, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
    input  busy, err_unexp_rd
  );
endinterface

// File: rtl/ddr3_app_arbiter.sv
// Two-client round-robin arbiter in front of the MIG 7-series app_* port.
// Serialises single-beat commands, sequences app_en / app_wdf_wren independently,
// and routes read returns back to the issuing client through an in-order tag FIFO.
module ddr3_app_arbiter #(
  parameter int ADDR_W    = 29,
  parameter int DATA_W    = 256,
  parameter int TAG_DEPTH = 8
) (
  input  logic              ui_clk,
  input  logic              rstn,
  ddr3_app_arbiter_if.slave bus
);
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0]       CMD_WR   = 3'b000;
  localparam logic [2:0]       CMD_RD   = 3'b001;
  localparam logic [CNT_W-1:0] TAG_FULL = CNT_W'(TAG_DEPTH);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t              r_state, w_state_nxt;

  logic                r_rr, w_rr_nxt;           // id of the client granted last
  logic                r_gnt_id, w_gnt_id_nxt;   // client owning the command in flight
  logic                r_cmd_done, w_cmd_done_nxt;
  logic                r_wdf_done, w_wdf_done_nxt;

  logic                r_app_en, w_app_en_nxt;
  logic [2:0]          r_app_cmd, w_app_cmd_nxt;
  logic [ADDR_W-1:0]   r_app_addr, w_app_addr_nxt;
  logic                r_app_wdf_wren, w_app_wdf_wren_nxt;
  logic [DATA_W-1:0]   r_app_wdf_data, w_app_wdf_data_nxt;

  logic                r_p0_ack, w_p0_ack_nxt;
  logic                r_p1_ack, w_p1_ack_nxt;
  logic                r_p0_rd_valid, w_p0_rd_valid_nxt;
  logic                r_p1_rd_valid, w_p1_rd_valid_nxt;
  logic [DATA_W-1:0]   r_rd_data, w_rd_data_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_err_unexp_rd, w_err_nxt;

  logic                r_tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0]    r_count, w_count_nxt;

  logic                w_elig0, w_elig1;
  logic                w_grant, w_grant_id;
  logic                w_sel_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_cmd_acc, w_wdf_acc, w_issue_done;
  logic                w_push, w_pop, w_unexp, w_pop_tag;

  // A client is eligible only in IDLE-time arbitration; reads also need a free tag slot.
  assign w_elig0 = bus.p0_req & ~r_p0_ack & bus.calib_done & (bus.p0_wr | (r_count < TAG_FULL));
  assign w_elig1 = bus.p1_req & ~r_p1_ack & bus.calib_done & (bus.p1_wr | (r_count < TAG_FULL));
  assign w_grant    = (r_state == S_IDLE) & (w_elig0 | w_elig1);
  assign w_grant_id = (w_elig0 & w_elig1) ? ~r_rr : w_elig1;

  assign w_sel_wr    = w_grant_id ? bus.p1_wr    : bus.p0_wr;
  assign w_sel_addr  = w_grant_id ? bus.p1_addr  : bus.p0_addr;
  assign w_sel_wdata = w_grant_id ? bus.p1_wdata : bus.p0_wdata;

  // Command and write data are accepted independently; a read starts with wdf already done.
  assign w_cmd_acc    = (r_state == S_ISSUE) & r_app_en & bus.app_rdy;
  assign w_wdf_acc    = (r_state == S_ISSUE) & r_app_wdf_wren & bus.app_wdf_rdy;
  assign w_issue_done = (r_state == S_ISSUE) & (r_cmd_done | w_cmd_acc) & (r_wdf_done | w_wdf_acc);

  assign w_push    = w_cmd_acc & (r_app_cmd == CMD_RD);
  assign w_pop     = bus.app_rd_data_valid & (r_count != '0);
  assign w_unexp   = bus.app_rd_data_valid & (r_count == '0);
  assign w_pop_tag = r_tag_mem[r_rptr];
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // State register
  always_ff @(posedge ui_clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: leave IDLE on a grant, return once both halves of the command are accepted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant)      w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_issue_done) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of every registered output and handshake flag
  always_comb begin
    w_rr_nxt           = r_rr;
    w_gnt_id_nxt       = r_gnt_id;
    w_cmd_done_nxt     = r_cmd_done;
    w_wdf_done_nxt     = r_wdf_done;
    w_app_en_nxt       = r_app_en;
    w_app_cmd_nxt      = r_app_cmd;
    w_app_addr_nxt     = r_app_addr;
    w_app_wdf_wren_nxt = r_app_wdf_wren;
    w_app_wdf_data_nxt = r_app_wdf_data;
    w_p0_ack_nxt       = 1'b0;
    w_p1_ack_nxt       = 1'b0;
    w_p0_rd_valid_nxt  = 1'b0;
    w_p1_rd_valid_nxt  = 1'b0;
    w_rd_data_nxt      = r_rd_data;
    w_err_nxt          = r_err_unexp_rd | w_unexp;

    if (w_grant) begin
      w_rr_nxt           = w_grant_id;
      w_gnt_id_nxt       = w_grant_id;
      w_cmd_done_nxt     = 1'b0;
      w_wdf_done_nxt     = ~w_sel_wr;
      w_app_en_nxt       = 1'b1;
      w_app_cmd_nxt      = w_sel_wr ? CMD_WR : CMD_RD;
      w_app_addr_nxt     = w_sel_addr;
      w_app_wdf_wren_nxt = w_sel_wr;
      w_app_wdf_data_nxt = w_sel_wdata;
    end

    if (w_cmd_acc) begin
      w_app_en_nxt   = 1'b0;
      w_cmd_done_nxt = 1'b1;
    end
    if (w_wdf_acc) begin
      w_app_wdf_wren_nxt = 1'b0;
      w_wdf_done_nxt     = 1'b1;
    end
    if (w_issue_done) begin
      w_p0_ack_nxt = ~r_gnt_id;
      w_p1_ack_nxt = r_gnt_id;
    end

    if (w_pop) begin
      w_rd_data_nxt     = bus.app_rd_data;
      w_p0_rd_valid_nxt = ~w_pop_tag;
      w_p1_rd_valid_nxt = w_pop_tag;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE) | (w_count_nxt != '0);
  end

  // Output and handshake registers
  always_ff @(posedge ui_clk) begin
    if (!rstn) begin
      r_rr           <= 1'b1;
      r_gnt_id       <= 1'b0;
      r_cmd_done     <= 1'b0;
      r_wdf_done     <= 1'b0;
      r_app_en       <= 1'b0;
      r_app_cmd      <= '0;
      r_app_addr     <= '0;
      r_app_wdf_wren <= 1'b0;
      r_app_wdf_data <= '0;
      r_p0_ack       <= 1'b0;
      r_p1_ack       <= 1'b0;
      r_p0_rd_valid  <= 1'b0;
      r_p1_rd_valid  <= 1'b0;
      r_rd_data      <= '0;
      r_busy         <= 1'b0;
      r_err_unexp_rd <= 1'b0;
    end else begin
      r_rr           <= w_rr_nxt;
      r_gnt_id       <= w_gnt_id_nxt;
      r_cmd_done     <= w_cmd_done_nxt;
      r_wdf_done     <= w_wdf_done_nxt;
      r_app_en       <= w_app_en_nxt;
      r_app_cmd      <= w_app_cmd_nxt;
      r_app_addr     <= w_app_addr_nxt;
      r_app_wdf_wren <= w_app_wdf_wren_nxt;
      r_app_wdf_data <= w_app_wdf_data_nxt;
      r_p0_ack       <= w_p0_ack_nxt;
      r_p1_ack       <= w_p1_ack_nxt;
      r_p0_rd_valid  <= w_p0_rd_valid_nxt;
      r_p1_rd_valid  <= w_p1_rd_valid_nxt;
      r_rd_data      <= w_rd_data_nxt;
      r_busy         <= w_busy_nxt;
      r_err_unexp_rd <= w_err_nxt;
    end
  end

  // Tag FIFO pointers and occupancy; reset discards any outstanding tags
  always_ff @(posedge ui_clk) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // Tag FIFO storage (granted client id per outstanding read)
  always_ff @(posedge ui_clk) begin
    if (w_push) r_tag_mem[r_wptr] <= r_gnt_id;
  end

  assign bus.app_en       = r_app_en;
  assign bus.app_cmd      = r_app_cmd;
  assign bus.app_addr     = r_app_addr;
  assign bus.app_wdf_wren = r_app_wdf_wren;
  assign bus.app_wdf_data = r_app_wdf_data;
  assign bus.app_wdf_end  = 1'b1;
  assign bus.app_wdf_mask = '0;
  assign bus.p0_ack       = r_p0_ack;
  assign bus.p1_ack       = r_p1_ack;
  assign bus.p0_rd_valid  = r_p0_rd_valid;
  assign bus.p1_rd_valid  = r_p1_rd_valid;
  assign bus.rd_data      = r_rd_data;
  assign bus.busy         = r_busy;
  assign bus.err_unexp_rd = r_err_unexp_rd;
endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Scoreboard bench for ddr3_app_arbiter: client driver, MIG model, read-return monitor.
module tb_ddr3_app_arbiter;
  localparam int ADDR_W    = 29;
  localparam int DATA_W    = 256;
  localparam int TAG_DEPTH = 8;

  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ddr3_app_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ddr3_app_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .ui_clk (clk),
    .rstn   (rstn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus and scoreboard state
  cmd_t              stim_q [2][$];
  cmd_t              exp_cmd_q [2][$];
  logic [DATA_W-1:0] exp_rd_q [2][$];
  logic [ADDR_W-1:0] mig_q [$];
  int                grant_log [$];
  bit                active [2];
  cmd_t              cur [2];
  int unsigned       req_cyc [2];
  int                wait_cnt [2];
  int                lat_last [2];
  int                n_acc [2];
  int                n_acked [2];
  int                en_cycles = 0;
  int                wren_cycles = 0;
  int                rd_acc = 0;
  int                wr_acc = 0;
  int                rdy_mode = 0;   // 0 always ready, 1 random, 2 never ready
  int                wdf_lag = 0;
  bit                hold_rd = 1'b0;
  int                unexp_req = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rdat(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W/32; i++) d[i*32 +: 32] = {3'(i), a} ^ 32'hA5C3_0F00;
    return d;
  endfunction

  function automatic cmd_t mk(input int n, input bit wr);
    cmd_t c;
    c.wr   = wr;
    c.addr = ADDR_W'($urandom());
    c.addr[ADDR_W-1] = n[0];
    for (int i = 0; i < DATA_W/32; i++) c.data[i*32 +: 32] = $urandom();
    return c;
  endfunction

  // Client driver: holds req/cmd until ack, records expected read data at issue time
  initial begin
    logic ack;
    for (int n = 0; n < 2; n++) begin
      cur[n].wr = 1'b0; cur[n].addr = '0; cur[n].data = '0;
      active[n] = 1'b0; n_acc[n] = 0; n_acked[n] = 0; lat_last[n] = 0; wait_cnt[n] = 0;
    end
    bus.p0_req = 1'b0; bus.p0_wr = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_wr = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    forever begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        ack = (n == 0) ? bus.p0_ack : bus.p1_ack;
        if (!rstn) begin
          active[n] = 1'b0;
          exp_cmd_q[n].delete();
          exp_rd_q[n].delete();
        end else begin
          if (ack) begin
            if (!active[n]) begin
              checks++; errors++;
              $display("FAIL ack_unexpected: client %0d got ack=1 required 0", n);
            end else begin
              active[n] = 1'b0;
              n_acked[n]++;
              lat_last[n] = int'(cyc - req_cyc[n]);
              check($sformatf("ack_after_accept_p%0d", n), DATA_W'(n_acc[n]), DATA_W'(n_acked[n]));
            end
          end else if (active[n]) begin
            wait_cnt[n]++;
            if (wait_cnt[n] > 400) begin
              checks++; errors++;
              $display("FAIL ack_timeout: client %0d no ack after %0d cycles, required ack", n, wait_cnt[n]);
              active[n] = 1'b0;
            end
          end
          if (!active[n] && stim_q[n].size() > 0) begin
            cur[n] = stim_q[n].pop_front();
            active[n] = 1'b1;
            wait_cnt[n] = 0;
            req_cyc[n] = cyc;
            exp_cmd_q[n].push_back(cur[n]);
            if (!cur[n].wr) exp_rd_q[n].push_back(rdat(cur[n].addr));
          end
        end
        if (n == 0) begin
          bus.p0_req = active[0]; bus.p0_wr = cur[0].wr; bus.p0_addr = cur[0].addr; bus.p0_wdata = cur[0].data;
        end else begin
          bus.p1_req = active[1]; bus.p1_wr = cur[1].wr; bus.p1_addr = cur[1].addr; bus.p1_wdata = cur[1].data;
        end
      end
    end
  end

  // MIG model: drives ready/return for the next edge and checks each command it will accept
  initial begin
    int   n;
    cmd_t e;
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0; bus.app_rd_data_valid = 1'b0; bus.app_rd_data = '0;
    begin
      int wdf_low;
      int unexp_done;
      wdf_low = 0; unexp_done = 0;
      forever begin
        @(negedge clk);
        case (rdy_mode)
          0:       begin bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1; end
          1:       begin bus.app_rdy = ($urandom_range(0, 3) != 0); bus.app_wdf_rdy = ($urandom_range(0, 3) != 0); end
          default: begin bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0; end
        endcase
        if (!bus.app_wdf_wren) wdf_low = 0;
        else if (wdf_low < wdf_lag) begin
          bus.app_wdf_rdy = 1'b0;
          wdf_low++;
        end
        bus.app_rd_data_valid = 1'b0;
        if (!rstn) mig_q.delete();
        else if (unexp_req != unexp_done) begin
          bus.app_rd_data_valid = 1'b1;
          bus.app_rd_data = rdat(ADDR_W'($urandom()));
          unexp_done++;
        end else if (!hold_rd && mig_q.size() > 0 && (rdy_mode != 1 || $urandom_range(0, 1) == 1)) begin
          bus.app_rd_data_valid = 1'b1;
          bus.app_rd_data = rdat(mig_q.pop_front());
        end
        if (bus.app_en) en_cycles++;
        if (bus.app_wdf_wren) wren_cycles++;
        if (rstn && bus.app_en && bus.app_rdy) begin
          n = int'(bus.app_addr[ADDR_W-1]);
          n_acc[n]++;
          grant_log.push_back(n);
          if (exp_cmd_q[n].size() == 0) begin
            checks++; errors++;
            $display("FAIL cmd_unexpected: app cmd %0h addr %0h with no pending request", bus.app_cmd, bus.app_addr);
          end else begin
            e = exp_cmd_q[n].pop_front();
            check("app_cmd", DATA_W'(bus.app_cmd), DATA_W'(e.wr ? 3'b000 : 3'b001));
            check("app_addr", DATA_W'(bus.app_addr), DATA_W'(e.addr));
            if (e.wr) begin
              check("app_wdf_data", bus.app_wdf_data, e.data);
              wr_acc++;
            end else begin
              mig_q.push_back(bus.app_addr);
              rd_acc++;
            end
          end
        end
      end
    end
  end

  // Read-return monitor: every rd_valid pulse must match the client's oldest outstanding read
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.p0_rd_valid) begin
          if (exp_rd_q[0].size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected_p0: p0_rd_valid=1 required 0 (no read outstanding)");
          end else check("rd_data_p0", bus.rd_data, exp_rd_q[0].pop_front());
        end
        if (bus.p1_rd_valid) begin
          if (exp_rd_q[1].size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected_p1: p1_rd_valid=1 required 0 (no read outstanding)");
          end else check("rd_data_p1", bus.rd_data, exp_rd_q[1].pop_front());
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int k;
    k = 0;
    while (k < limit && !(stim_q[0].size() == 0 && stim_q[1].size() == 0 && !active[0] && !active[1] &&
                          bus.busy == 1'b0 && exp_rd_q[0].size() == 0 && exp_rd_q[1].size() == 0)) begin
      tick(1);
      k++;
    end
    checks++;
    if (k >= limit) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, limit);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, DATA_W'({bus.app_en, bus.app_wdf_wren, bus.app_cmd, bus.p0_ack, bus.p1_ack,
                                  bus.p0_rd_valid, bus.p1_rd_valid, bus.busy, bus.err_unexp_rd, bus.app_wdf_end}),
          DATA_W'(12'b0000_0000_0001));
    check({tag, "_addr"}, DATA_W'(bus.app_addr), '0);
    check({tag, "_wdata"}, bus.app_wdf_data, '0);
    check({tag, "_rdata"}, bus.rd_data, '0);
    check({tag, "_mask"}, DATA_W'(bus.app_wdf_mask), '0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  initial begin
    cmd_t c;
    int   e0, w0, g0, r0, a0;
    bus.calib_done = 1'b1;
    rstn = 1'b0;
    tick(3);
    check_quiet("reset");
    rstn = 1'b1;
    tick(2);

    // single write, MIG always ready
    c.wr = 1'b1; c.addr = ADDR_W'(32'h40); c.data = {8{32'hcafebabe}};
    e0 = en_cycles; w0 = wren_cycles;
    stim_q[0].push_back(c);
    wait_idle(100, "single_write");
    check("wr_latency", DATA_W'(lat_last[0]), DATA_W'(2));
    check("wr_en_cycles", DATA_W'(en_cycles - e0), DATA_W'(1));
    check("wr_wren_cycles", DATA_W'(wren_cycles - w0), DATA_W'(1));

    // write data accepted 5 cycles after the command
    wdf_lag = 5;
    c.addr = ADDR_W'(32'h80);
    e0 = en_cycles; w0 = wren_cycles;
    stim_q[0].push_back(c);
    wait_idle(100, "wdf_lag_write");
    wdf_lag = 0;
    check("lag_latency", DATA_W'(lat_last[0]), DATA_W'(7));
    check("lag_en_cycles", DATA_W'(en_cycles - e0), DATA_W'(1));
    check("lag_wren_cycles", DATA_W'(wren_cycles - w0), DATA_W'(6));

    // both clients requesting continuously: grants alternate starting with p0
    do_reset();
    g0 = grant_log.size();
    for (int i = 0; i < 6; i++) begin
      stim_q[0].push_back(mk(0, 1'b1));
      stim_q[1].push_back(mk(1, 1'b1));
    end
    wait_idle(300, "alternate");
    check("alt_count", DATA_W'(grant_log.size() - g0), DATA_W'(12));
    for (int i = 0; i < 12; i++)
      check($sformatf("alt_grant%0d", i), DATA_W'(grant_log[g0 + i]), DATA_W'(i % 2));

    // nine reads with returns withheld: eight issue, ninth stalls, writes still pass
    hold_rd = 1'b1;
    r0 = rd_acc;
    for (int i = 0; i < 5; i++) begin
      stim_q[0].push_back(mk(0, 1'b0));
      if (i < 4) stim_q[1].push_back(mk(1, 1'b0));
    end
    tick(60);
    check("full_reads_issued", DATA_W'(rd_acc - r0), DATA_W'(TAG_DEPTH));
    check("full_busy", DATA_W'(bus.busy), DATA_W'(1));
    a0 = wr_acc;
    stim_q[1].push_back(mk(1, 1'b1));
    tick(20);
    check("full_write_passes", DATA_W'(wr_acc - a0), DATA_W'(1));
    check("full_still_stalled", DATA_W'(rd_acc - r0), DATA_W'(TAG_DEPTH));
    hold_rd = 1'b0;
    wait_idle(300, "full_release");
    check("full_reads_total", DATA_W'(rd_acc - r0), DATA_W'(9));

    // read data with nothing outstanding
    unexp_req++;
    tick(3);
    check("unexp_err_set", DATA_W'(bus.err_unexp_rd), DATA_W'(1));
    tick(10);
    check("unexp_err_sticky", DATA_W'(bus.err_unexp_rd), DATA_W'(1));
    do_reset();
    check("unexp_err_cleared", DATA_W'(bus.err_unexp_rd), DATA_W'(0));

    // calibration not done: nothing granted
    bus.calib_done = 1'b0;
    e0 = en_cycles;
    stim_q[0].push_back(mk(0, 1'b1));
    stim_q[1].push_back(mk(1, 1'b0));
    tick(20);
    check("calib_no_en", DATA_W'(en_cycles - e0), DATA_W'(0));
    check("calib_not_busy", DATA_W'(bus.busy), DATA_W'(0));
    bus.calib_done = 1'b1;
    wait_idle(200, "calib_release");

    // reset in the middle of an ISSUE
    rdy_mode = 2;
    stim_q[0].push_back(mk(0, 1'b1));
    begin
      int k;
      k = 0;
      while (k < 20 && !bus.app_en) begin tick(1); k++; end
    end
    check("mid_issue_en", DATA_W'(bus.app_en), DATA_W'(1));
    rstn = 1'b0;
    tick(1);
    check_quiet("mid_reset");
    rstn = 1'b1;
    rdy_mode = 0;
    tick(3);

    // randomised mixed traffic with random readiness and return pacing
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      stim_q[0].push_back(mk(0, $urandom_range(0, 1) == 1));
      stim_q[1].push_back(mk(1, $urandom_range(0, 1) == 1));
    end
    wait_idle(5000, "random_traffic");
    check("random_acks", DATA_W'(n_acked[0] + n_acked[1]), DATA_W'(n_acc[0] + n_acc[1]));
    check("random_no_err", DATA_W'(bus.err_unexp_rd), DATA_W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
